// File: rtl/mac_result_quantizer.sv
// mac_result_quantizer: drains one mkMACBuff block, requantizes each result
// into a local buffer and replays it to the next layer over ready/valid.
module mac_result_quantizer #(
    parameter int RES_WIDTH = 34,
    parameter int OUT_WIDTH = 16,
    parameter int DEPTH     = 64,
    parameter int LOGDEPTH  = 6
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 EN_start,
    output logic                 RDY_start,
    input  logic [4:0]           shift_amt,
    input  logic                 RDY_blockRead,
    output logic                 EN_blockRead,
    input  logic                 VALID_memVal,
    input  logic [RES_WIDTH-1:0] memVal_data,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err_extra
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RUN
    } state_t;

    localparam int CW = LOGDEPTH + 1;
    localparam int RW = RES_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
    localparam logic [RW-1:0] ONE_W   = RW'(1);
    localparam logic [RW-1:0] SAT_W   =
        {{(RW - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    state_t               state_q, state_d;
    logic [4:0]           shift_q, shift_d;
    logic [CW-1:0]        cap_cnt_q, cap_cnt_d;
    logic [CW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [OUT_WIDTH-1:0] s1_data_q, s1_data_d;

    logic [OUT_WIDTH-1:0] mem_q [DEPTH];

    logic [RW-1:0]        rnd_bias;
    logic [RW-1:0]        rounded;
    logic [RW-1:0]        shifted;
    logic [OUT_WIDTH-1:0] quant;

    logic                 run;
    logic                 cap_ok;
    logic                 mem_we;
    logic                 hs;

    // Round-half-up shift followed by unsigned saturation.
    always_comb begin
        rnd_bias = '0;
        if (shift_q != 5'd0) begin
            rnd_bias = ONE_W << (shift_q - 5'd1);
        end
        rounded = {1'b0, memVal_data} + rnd_bias;
        shifted = rounded >> shift_q;
        if (shifted > SAT_W) begin
            quant = '1;
        end else begin
            quant = shifted[OUT_WIDTH-1:0];
        end
    end

    // Drain side view of the buffer; data is forced to zero when nothing
    // is offered so the port has a defined value out of reset.
    always_comb begin
        run          = (state_q == RUN);
        out_valid    = run && (rd_ptr_q < wr_ptr_q);
        out_data     = '0;
        if (out_valid) begin
            out_data = mem_q[rd_ptr_q[LOGDEPTH-1:0]];
        end
        out_last     = out_valid && (rd_ptr_q == LAST_C);
        hs           = out_valid && out_ready;
        cap_ok       = run && (cap_cnt_q < DEPTH_C);
        mem_we       = s1_valid_q && (wr_ptr_q < DEPTH_C);
        RDY_start    = (state_q == IDLE);
        busy         = (state_q != IDLE);
        EN_blockRead = (state_q == REQ) && RDY_blockRead;
        done         = done_q;
        err_extra    = err_q;
    end

    // Next-state logic: FSM, capture counters and the sticky error flag.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cap_cnt_d  = cap_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q;
        done_d     = 1'b0;
        s1_valid_d = 1'b0;
        s1_data_d  = s1_data_q;

        unique case (state_q)
            IDLE: begin
                if (EN_start) begin
                    shift_d   = shift_amt;
                    cap_cnt_d = '0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    err_d     = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (RDY_blockRead) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (VALID_memVal && cap_ok) begin
                    s1_valid_d = 1'b1;
                    s1_data_d  = quant;
                    cap_cnt_d  = cap_cnt_q + 1'b1;
                end
                if (mem_we) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (hs) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (out_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // memVal has no backpressure, so any beat we cannot take is flagged.
        if (VALID_memVal && !cap_ok) begin
            err_d = 1'b1;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cap_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cap_cnt_q  <= cap_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    // Result buffer; contents need no reset since pointers gate visibility.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[LOGDEPTH-1:0]] <= s1_data_q;
        end
    end

endmodule
